div_unit: RTL and testbench

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions in the forwarding pipeline's execute stage. It runs a 32-iteration restoring division and resolves each trial subtraction with the same borrow rule as the SLT/SLTU comparator: unsigned `a >= b` exactly when the subtractor's `carry_out` is 1. The pipeline control stalls execute while `o_busy` is high and captures `o_y` on the `o_valid` pulse.

---
 rtl/div_pkg.sv | 7 +
 rtl/add_sub_32bit.sv | 14 +
 rtl/div_unit.sv | 84 ++++++++
 tb/tb_div_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle integer divider.
package div_pkg;
  typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/add_sub_32bit.sv
// add_sub_32bit: 32-bit adder/subtractor; for subtraction carry_out=1 means a >= b unsigned.
module add_sub_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        add_sub,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);
  logic [31:0] bx;
  assign bx = b ^ {32{add_sub}};
  assign {carry_out, sum} = {1'b0, a} + {1'b0, bx} + {32'b0, add_sub};
  assign overflow = (a[31] == bx[31]) && (sum[31] != a[31]);
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-iteration restoring divider for RV32M DIV/DIVU/REM/REMU.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_y
);
  div_state_e state;
  div_op_e op;
  logic [4:0] cnt;
  logic [WIDTH-1:0] r, q, bm, a_mag, b_mag, r_sh, trial;
  logic q_neg, r_neg, sgn, ge, unused_ovf;
  assign sgn = !i_op[0];
  assign a_mag = (sgn && i_a[WIDTH-1]) ? -i_a : i_a;
  assign b_mag = (sgn && i_b[WIDTH-1]) ? -i_b : i_b;
  assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
  add_sub_32bit u_sub (
    .a(r_sh),
    .b(bm),
    .add_sub(1'b1),
    .sum(trial),
    .carry_out(ge),
    .overflow(unused_ovf)
  );
  assign o_busy = state != IDLE;
  assign o_valid = (state == DONE) && !i_flush;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      op <= DIV;
      cnt <= '0;
      r <= '0;
      q <= '0;
      bm <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      o_y <= '0;
    end else if (i_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          op <= div_op_e'(i_op);
          if (i_b == '0) begin
            o_y <= i_op[1] ? i_a : '1;
            state <= DONE;
          end else if (sgn && i_a == INT_MIN && i_b == '1) begin
            o_y <= i_op[1] ? '0 : INT_MIN;
            state <= DONE;
          end else begin
            state <= CALC;
            cnt <= '0;
            r <= '0;
            q <= a_mag;
            bm <= b_mag;
            q_neg <= sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg <= sgn && i_a[WIDTH-1];
          end
        end
        CALC: begin
          r <= ge ? trial : r_sh;
          q <= {q[WIDTH-2:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_ITER - 1)) state <= FIX;
        end
        FIX: begin
          o_y <= (op == REM || op == REMU) ? (r_neg ? -r : r) : (q_neg ? -q : q);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors and timing checks.
module tb_div_unit;
  typedef struct {
    logic [31:0] y;
    int cyc;
    string name;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [31:0] a = 0, b = 0;
  logic [1:0] op = 0;
  logic busy, valid;
  logic [31:0] y;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  div_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_op(op),
    .i_flush(flush), .o_busy(busy), .o_valid(valid), .o_y(y)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) begin
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_valid: got y=%h at cycle %0d, required no valid", y, cyc);
    end else begin
      exp_t e;
      e = sb.pop_front();
      if (y !== e.y) begin
        errors++;
        $display("FAIL %s: got y=%h, required %h", e.name, y, e.y);
      end
      checks++;
      if (cyc != e.cyc) begin
        errors++;
        $display("FAIL %s_cycle: got valid at cycle %0d, required %0d", e.name, cyc, e.cyc);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                       input bit push, input logic [31:0] exp, input int lat, input string name);
    start = 1; a = ia; b = ib; op = iop;
    if (push) sb.push_back('{exp, cyc + lat, name});
    @(posedge clk); #1 start = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                     input logic [31:0] exp, input int lat, input string name);
    issue(ia, ib, iop, 1, exp, lat, name);
    drain();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_valid", {31'b0, valid}, 0);
    chk("reset_y", y, 0);
    rst = 0;
    @(posedge clk); #1;
    issue(100, 7, 2'b00, 1, 14, 34, "div_100_7");
    chk("busy_cycle1", {31'b0, busy}, 1);
    drain();
    chk("busy_after_done", {31'b0, busy}, 0);
    run(100, 7, 2'b10, 2, 34, "rem_100_7");
    run(-32'sd100, 7, 2'b00, 32'hFFFF_FFF2, 34, "div_m100_7");
    run(-32'sd100, 7, 2'b10, 32'hFFFF_FFFE, 34, "rem_m100_7");
    run(7, -32'sd2, 2'b00, 32'hFFFF_FFFD, 34, "div_7_m2");
    run(7, -32'sd2, 2'b10, 1, 34, "rem_7_m2");
    run(32'hFFFF_FFFF, 2, 2'b01, 32'h7FFF_FFFF, 34, "divu_max_2");
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 0, 34, "divu_min_max");
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h8000_0000, 34, "remu_min_max");
    run(32'h1234_5678, 0, 2'b00, 32'hFFFF_FFFF, 1, "div_by_zero");
    run(32'h1234_5678, 0, 2'b11, 32'h1234_5678, 1, "remu_by_zero");
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1, "div_ovf");
    run(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 0, 1, "rem_ovf");
    issue(9, 3, 2'b01, 1, 3, 1 + 34, "late_divu_9_3");
    sb[0].cyc = cyc - 1 + 34;
    drain();
    issue(32'hFFFF_FFFF, 2, 2'b01, 1, 32'h7FFF_FFFF, 34, "busy_start_ignored");
    repeat (4) @(posedge clk);
    #1 start = 1; a = 1; b = 1; op = 2'b00;
    @(posedge clk); #1 start = 0;
    drain();
    issue(100, 7, 2'b00, 0, 0, 0, "flushed_div");
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("busy_after_flush", {31'b0, busy}, 0);
    chk("y_kept_after_flush", y, 32'h7FFF_FFFF);
    issue(9, 3, 2'b01, 1, 3, 34, "divu_after_flush");
    drain();
    issue(100, 7, 2'b01, 0, 0, 0, "reset_victim");
    repeat (19) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_valid", {31'b0, valid}, 0);
    chk("async_rst_y", y, 0);
    @(posedge clk); #1 rst = 0;
    issue(9, 3, 2'b01, 1, 3, 34, "divu_after_reset");
    drain();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
